// File: rtl/mbm_access_initiator.sv
// Initiator for Multi_Bank_Memory: write/read request streams in, registered memory strobes out, in-order read responses.
// Optional MBM_CONFLICT_CNT_EN adds a saturating count of write-stall cycles caused by bank conflicts.
module mbm_access_initiator #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 8,
  parameter int BANK_LSB  = 7,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef MBM_CONFLICT_CNT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              rd_fire;
  logic              wr_fire;
  logic              bank_conflict;
  logic              rd_cap_reg;
  logic [CNT_W:0]    credit_used;
  logic              fifo_push;
  logic              fifo_pop;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] entry_data [RSP_DEPTH];

  assign bank_conflict = (rd_addr[ADDR_W-1:BANK_LSB] == wr_addr[ADDR_W-1:BANK_LSB]);

  // Credit covers queued responses plus reads still travelling through the memory.
  assign credit_used = {1'b0, count_reg} + (CNT_W+1)'(mem_ren) + (CNT_W+1)'(rd_cap_reg);
  assign rd_ready    = rst_n && (credit_used < (CNT_W+1)'(RSP_DEPTH));
  assign rd_fire     = rd_valid && rd_ready;

  // Reads win same-bank collisions, so a same-address pair returns the old data.
  assign wr_ready = rst_n && !(rd_fire && bank_conflict);
  assign wr_fire  = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_raddr  <= '0;
      mem_waddr  <= '0;
      mem_din    <= '0;
      rd_cap_reg <= 1'b0;
    end else begin
      mem_ren    <= rd_fire;
      mem_wen    <= wr_fire;
      rd_cap_reg <= mem_ren;
      if (rd_fire) begin
        mem_raddr <= rd_addr;
      end
      if (wr_fire) begin
        mem_waddr <= wr_addr;
        mem_din   <= wr_data;
      end
    end
  end

  // Response FIFO, first-word fall-through; mem_dout is valid the cycle after ren is sampled.
  assign fifo_push = rd_cap_reg;
  assign rsp_valid = (count_reg != '0);
  assign fifo_pop  = rsp_valid && rsp_ready;
  assign rsp_data  = entry_data[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < RSP_DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (fifo_push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= mem_dout;
        end
      end
      assign entry_data[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef MBM_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_reg <= '0;
    end else if (wr_valid && rd_fire && bank_conflict && (conflict_cnt_reg != 16'hFFFF)) begin
      conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
    end
  end

  assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_mbm_access_initiator.sv
// Scoreboard bench for mbm_access_initiator with a behavioural single-port-per-direction memory model.
// Define MBM_CONFLICT_CNT_EN to also check the conflict counter.
module tb_mbm_access_initiator;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid = 1'b0;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout = '0;
`ifdef MBM_CONFLICT_CNT_EN
  logic [15:0]       conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mem_model [2048];
  logic [DATA_W-1:0] ref_mem [2048];

  always #5 clk = ~clk;

  mbm_access_initiator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_raddr (mem_raddr),
    .mem_waddr (mem_waddr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
`ifdef MBM_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  // Memory: samples ren/wen at the edge after issue; a read sees the contents before a same-edge write.
  always @(posedge clk) begin
    if (mem_wen) mem_model[mem_waddr] <= mem_din;
    if (mem_ren) mem_dout <= mem_model[mem_raddr];
  end

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return 8'((a * 7 + 3) ^ (a >> 3));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_cc(input string name, input int exp);
`ifdef MBM_CONFLICT_CNT_EN
    check(name, 32'(conflict_cnt), 32'(exp));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle read with an expected response pushed at the handshake.
  task automatic issue_rd(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    rd_valid = 1'b1;
    rd_addr  = a;
    #1;
    check(name, 32'(rd_ready), 32'd1);
    if (rd_ready) exp_q.push_back(e);
    step();
    rd_valid = 1'b0;
    $display("rd 0x%03h issued, expect 0x%02h", a, e);
  endtask

  // Monitor: pops and compares each consumed response; also checks hold stability under backpressure.
  initial begin
    logic              hold_v;
    logic [DATA_W-1:0] hold_d;
    logic [DATA_W-1:0] e;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (hold_v) check("rsp_stable", 32'(rsp_data), 32'(hold_d));
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got 0x%02h, expected no response", rsp_data);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(e));
            $display("rsp 0x%02h (expected 0x%02h)", rsp_data, e);
          end
        end
      end
      hold_v = rst_n && rsp_valid && !rsp_ready;
      hold_d = rsp_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    bit got;
    for (int i = 0; i < 2048; i++) begin
      mem_model[i] = init_val(i);
      ref_mem[i]   = init_val(i);
    end

    // Reset state, with requests asserted to show the readies are gated.
    #2 rst_n = 1'b0;
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_ready", 32'(rd_ready), 32'd0);
    check("rst_mem_ren", 32'(mem_ren), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_cc("rst_conflict_cnt", 0);
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1: write then read, 3-cycle latency
    wr_valid = 1'b1;
    wr_addr  = 11'h057;
    wr_data  = 8'h57;
    #1;
    check("t1_wr_ready", 32'(wr_ready), 32'd1);
    step();
    ref_mem[11'h057] = 8'h57;
    wr_valid = 1'b0;
    check("t1_mem_wen", 32'(mem_wen), 32'd1);
    check("t1_mem_waddr", 32'(mem_waddr), 32'h057);
    check("t1_mem_din", 32'(mem_din), 32'h57);
    $display("wr 0x057 <- 0x57 issued");
    step();
    check("t1_wen_one_cycle", 32'(mem_wen), 32'd0);
    rd_valid = 1'b1;
    rd_addr  = 11'h057;
    #1;
    check("t1_rd_ready", 32'(rd_ready), 32'd1);
    exp_q.push_back(8'h57);
    step();
    rd_valid = 1'b0;
    check("t1_mem_ren", 32'(mem_ren), 32'd1);
    check("t1_mem_raddr", 32'(mem_raddr), 32'h057);
    check("t1_rsp_valid_e0", 32'(rsp_valid), 32'd0);
    step();
    check("t1_ren_one_cycle", 32'(mem_ren), 32'd0);
    check("t1_rsp_valid_e1", 32'(rsp_valid), 32'd0);
    step();
    check("t1_rsp_valid_e2", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data_e2", 32'(rsp_data), 32'h57);
    step();

    // 2: same-bank collision, read wins
    check_cc("t2_cc_before", 0);
    rd_valid = 1'b1;
    rd_addr  = 11'h28F;
    wr_valid = 1'b1;
    wr_addr  = 11'h299;
    wr_data  = 8'h99;
    #1;
    check("t2_rd_ready", 32'(rd_ready), 32'd1);
    check("t2_wr_ready", 32'(wr_ready), 32'd0);
    exp_q.push_back(ref_mem[11'h28F]);
    step();
    rd_valid = 1'b0;
    check("t2_mem_ren", 32'(mem_ren), 32'd1);
    check("t2_mem_wen", 32'(mem_wen), 32'd0);
    check_cc("t2_cc_after", 1);
    #1;
    check("t2_wr_ready_next", 32'(wr_ready), 32'd1);
    step();
    ref_mem[11'h299] = 8'h99;
    wr_valid = 1'b0;
    check("t2_mem_wen_next", 32'(mem_wen), 32'd1);
    check("t2_mem_waddr", 32'(mem_waddr), 32'h299);
    check("t2_mem_din", 32'(mem_din), 32'h99);
    check_cc("t2_cc_hold", 1);
    $display("rd 0x28F + wr 0x299 collision done");
    repeat (3) step();

    // 3: different banks, both issue together
    rd_valid = 1'b1;
    rd_addr  = 11'h77F;
    wr_valid = 1'b1;
    wr_addr  = 11'h57F;
    wr_data  = 8'h5F;
    #1;
    check("t3_rd_ready", 32'(rd_ready), 32'd1);
    check("t3_wr_ready", 32'(wr_ready), 32'd1);
    exp_q.push_back(ref_mem[11'h77F]);
    step();
    ref_mem[11'h57F] = 8'h5F;
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    check("t3_mem_ren", 32'(mem_ren), 32'd1);
    check("t3_mem_wen", 32'(mem_wen), 32'd1);
    check("t3_mem_raddr", 32'(mem_raddr), 32'h77F);
    check("t3_mem_waddr", 32'(mem_waddr), 32'h57F);
    check_cc("t3_cc", 1);
    $display("rd 0x77F + wr 0x57F parallel done");
    repeat (3) step();

    // 4: same address read/write returns old data, later read sees new
    rd_valid = 1'b1;
    rd_addr  = 11'h057;
    wr_valid = 1'b1;
    wr_addr  = 11'h057;
    wr_data  = 8'hAA;
    #1;
    check("t4_rd_ready", 32'(rd_ready), 32'd1);
    check("t4_wr_ready", 32'(wr_ready), 32'd0);
    exp_q.push_back(8'h57);
    step();
    rd_valid = 1'b0;
    #1;
    check("t4_wr_ready_next", 32'(wr_ready), 32'd1);
    step();
    ref_mem[11'h057] = 8'hAA;
    wr_valid = 1'b0;
    check("t4_mem_wen", 32'(mem_wen), 32'd1);
    check_cc("t4_cc", 2);
    repeat (2) step();
    issue_rd("t4_rd2_ready", 11'h057, 8'hAA);
    repeat (4) step();

    // 5: credit limit under backpressure
    rsp_ready = 1'b0;
    rd_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 11'(11'h100 + i);
      #1;
      check("t5_rd_ready_credit", 32'(rd_ready), 32'd1);
      if (rd_ready) exp_q.push_back(ref_mem[11'h100 + i]);
      step();
      $display("rd 0x%03h accepted under backpressure", rd_addr);
    end
    rd_addr = 11'h104;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t5_rd_ready_full", 32'(rd_ready), 32'd0);
      step();
    end
    check("t5_rsp_valid_full", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (rd_ready) begin
        exp_q.push_back(ref_mem[11'h104]);
        got = 1'b1;
      end
      step();
    end
    rd_valid = 1'b0;
    check("t5_fifth_accepted", 32'(got), 32'd1);
    $display("rd 0x104 accepted after release");
    repeat (8) step();

    // 6: reset with reads in flight
    rd_valid = 1'b1;
    rd_addr  = 11'h200;
    step();
    rd_addr  = 11'h201;
    step();
    wr_valid = 1'b1;
    wr_addr  = 11'h300;
    rst_n    = 1'b0;
    #1;
    check("t6_mem_ren", 32'(mem_ren), 32'd0);
    check("t6_mem_wen", 32'(mem_wen), 32'd0);
    check("t6_mem_raddr", 32'(mem_raddr), 32'd0);
    check("t6_mem_waddr", 32'(mem_waddr), 32'd0);
    check("t6_mem_din", 32'(mem_din), 32'd0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_rsp_data", 32'(rsp_data), 32'd0);
    check("t6_rd_ready", 32'(rd_ready), 32'd0);
    check("t6_wr_ready", 32'(wr_ready), 32'd0);
    check_cc("t6_cc", 0);
    step();
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    check("t6_no_rsp_after_reset", 32'(seen), 32'd0);
    $display("reset mid-flight done");
    issue_rd("t6_rd_after_reset", 11'h200, ref_mem[11'h200]);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
